// File: rtl/conv.sv
// Pipelined SIZE x SIZE fixed-point window dot product: register windows,
// register full-precision products, then sum, rescale and saturate.
module conv #(
  parameter int unsigned SIZE = 7,
  parameter int unsigned N    = 32,
  parameter int unsigned FRAC = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [SIZE*SIZE*N-1:0] filter,
  input  logic [SIZE*SIZE*N-1:0] conv_input,
  output logic                   out_valid,
  output logic [N-1:0]           conv_output
);

  localparam int unsigned E  = SIZE * SIZE;
  localparam int unsigned PW = 2 * N;
  localparam int unsigned AW = PW + $clog2(E);

  logic [E*N-1:0] filt_q, filt_d;
  logic [E*N-1:0] data_q, data_d;
  logic           v1_q, v1_d;

  logic [PW-1:0]  prod_q [E];
  logic [PW-1:0]  prod_d [E];
  logic           v2_q, v2_d;

  logic [N-1:0]   res_q, res_d;
  logic           v3_q, v3_d;

  // Stage 1: capture windows; data holds while idle
  always_comb begin
    v1_d   = in_valid;
    filt_d = filt_q;
    data_d = data_q;
    if (in_valid) begin
      filt_d = filter;
      data_d = conv_input;
    end
  end

  // Stage 2: signed products at full 2N-bit precision
  always_comb begin : stage2
    logic signed [N-1:0]  a;
    logic signed [N-1:0]  b;
    logic signed [PW-1:0] p;
    a = '0;
    b = '0;
    p = '0;
    for (int unsigned i = 0; i < E; i++) begin
      a         = filt_q[i*N +: N];
      b         = data_q[i*N +: N];
      p         = a * b;
      prod_d[i] = p;
    end
    v2_d = v1_q;
  end

  // Stage 3: wide sum, arithmetic rescale, saturate to N bits
  always_comb begin : stage3
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] shifted;
    logic [AW-N:0]        hi;
    logic [N-1:0]         sat;
    acc = '0;
    for (int unsigned i = 0; i < E; i++) begin
      acc = acc + {{(AW-PW){prod_q[i][PW-1]}}, prod_q[i]};
    end
    shifted = acc >>> FRAC;
    hi      = shifted[AW-1:N-1];
    if ((&hi) || !(|hi)) begin
      sat = shifted[N-1:0];
    end else if (shifted[AW-1]) begin
      sat = {1'b1, {(N-1){1'b0}}};
    end else begin
      sat = {1'b0, {(N-1){1'b1}}};
    end
    res_d = v2_q ? sat : res_q;
    v3_d  = v2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      data_q <= '0;
      v1_q   <= 1'b0;
      for (int unsigned i = 0; i < E; i++) begin
        prod_q[i] <= '0;
      end
      v2_q   <= 1'b0;
      res_q  <= '0;
      v3_q   <= 1'b0;
    end else begin
      filt_q <= filt_d;
      data_q <= data_d;
      v1_q   <= v1_d;
      for (int unsigned i = 0; i < E; i++) begin
        prod_q[i] <= prod_d[i];
      end
      v2_q   <= v2_d;
      res_q  <= res_d;
      v3_q   <= v3_d;
    end
  end

  assign out_valid   = v3_q;
  assign conv_output = res_q;

endmodule

// File: tb/tb_conv.sv
// Directed table-driven bench for conv plus streaming and reset sequences.
module tb_conv;

  localparam int unsigned SIZE = 7;
  localparam int unsigned N    = 32;
  localparam int unsigned FRAC = 15;
  localparam int unsigned E    = SIZE * SIZE;
  localparam int unsigned W    = E * N;

  typedef struct {
    string       name;
    logic [W-1:0] f;
    logic [W-1:0] d;
    logic [N-1:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] filter;
  logic [W-1:0] conv_input;
  logic         out_valid;
  logic [N-1:0] conv_output;

  int total = 0;
  int bad   = 0;

  vec_t tbl[10];
  vec_t strm[5];

  conv #(.SIZE(SIZE), .N(N), .FRAC(FRAC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .filter     (filter),
    .conv_input (conv_input),
    .out_valid  (out_valid),
    .conv_output(conv_output)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fillw(input logic [N-1:0] v);
    logic [W-1:0] w;
    for (int i = 0; i < E; i++) w[i*N +: N] = v;
    return w;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: out_valid got %b expected %b", name, act, exp);
    end
  endtask

  // One isolated window: result must appear exactly after the third edge and then hold.
  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    in_valid   = 1'b1;
    filter     = v.f;
    conv_input = v.d;
    @(posedge clk); #1;
    chk_v({v.name, " edge0"}, out_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_v({v.name, " edge1"}, out_valid, 1'b0);
    @(posedge clk); #1;
    chk_v({v.name, " edge2"}, out_valid, 1'b1);
    chk({v.name, " result"}, conv_output, v.exp);
    @(posedge clk); #1;
    chk_v({v.name, " drop"}, out_valid, 1'b0);
    chk({v.name, " hold"}, conv_output, v.exp);
  endtask

  initial begin
    logic [W-1:0] w;

    // Table: hand-computed Q16.15 results
    w = '0;
    for (int i = 1; i < E; i += 2) w[i*N +: N] = 32'h0000_8000;
    tbl[0] = '{"alt_ones", w, w, 32'h000C_0000};
    tbl[1] = '{"all_half", fillw(32'h0000_4000), fillw(32'h0000_4000), 32'h0006_2000};
    w = '0;
    w[10*N +: N] = 32'h0000_0001;
    tbl[2] = '{"lsb_trunc", w, fillw(32'h0000_4000), 32'h0000_0000};
    tbl[3] = '{"neg_one_x_two", fillw(32'hFFFF_8000), fillw(32'h0001_0000), 32'hFFCF_0000};
    w = '0;
    for (int i = 0; i < 24; i++) w[i*N +: N] = 32'h0000_8000;
    for (int i = 24; i < 48; i++) w[i*N +: N] = 32'hFFFF_8000;
    tbl[4] = '{"cancel", fillw(32'h0000_8000), w, 32'h0000_0000};
    tbl[5] = '{"sat_max", fillw(32'h7FFF_FFFF), fillw(32'h7FFF_FFFF), 32'h7FFF_FFFF};
    tbl[6] = '{"sat_min", fillw(32'h7FFF_FFFF), fillw(32'h8000_0000), 32'h8000_0000};
    w = '0;
    w[0 +: N] = 32'hFFFF_FFFF;
    tbl[7] = '{"floor_neg", w, fillw(32'h0000_4000), 32'hFFFF_FFFF};
    w = '0;
    w[0 +: N] = 32'h8000_0000;
    tbl[8] = '{"minsq", w, w, 32'h7FFF_FFFF};
    w = '0;
    w[3*N +: N] = 32'h0001_8000;
    tbl[9] = '{"mixed", w, fillw(32'hFFFE_C000), 32'hFFFC_4000};

    // Streaming windows: (j+1).0 * 2.0 at element j -> (j+1)*2.0
    for (int j = 0; j < 5; j++) begin
      strm[j].name = $sformatf("stream%0d", j);
      strm[j].f    = '0;
      strm[j].f[j*N +: N] = N'((j + 1) << FRAC);
      strm[j].d    = fillw(32'h0001_0000);
      strm[j].exp  = N'((j + 1) << 16);
    end

    // Reset held while windows are offered
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    filter     = tbl[5].f;
    conv_input = tbl[5].d;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_v("in_reset valid", out_valid, 1'b0);
      chk("in_reset data", conv_output, '0);
    end

    // Release with in_valid already high: first edge accepts
    @(negedge clk);
    rst_n      = 1'b1;
    filter     = tbl[0].f;
    conv_input = tbl[0].d;
    @(posedge clk); #1;
    chk_v("first edge0", out_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_v("first edge1", out_valid, 1'b0);
    @(posedge clk); #1;
    chk_v("first edge2", out_valid, 1'b1);
    chk("first result", conv_output, tbl[0].exp);
    @(posedge clk); #1;
    chk_v("first drop", out_valid, 1'b0);

    for (int k = 0; k < 10; k++) apply_vec(tbl[k]);

    // Back-to-back stream: window c accepted on cycle c, seen at cycle c+2
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 5) begin
        in_valid   = 1'b1;
        filter     = strm[c].f;
        conv_input = strm[c].d;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (c >= 2 && c - 2 < 5) begin
        chk_v({strm[c-2].name, " valid"}, out_valid, 1'b1);
        chk({strm[c-2].name, " result"}, conv_output, strm[c-2].exp);
      end else begin
        chk_v($sformatf("stream idle%0d", c), out_valid, 1'b0);
      end
    end

    // Reset asserted after the second accept discards everything in flight
    @(negedge clk);
    in_valid   = 1'b1;
    filter     = strm[0].f;
    conv_input = strm[0].d;
    @(negedge clk);
    filter     = strm[1].f;
    conv_input = strm[1].d;
    @(posedge clk); #2;
    rst_n = 1'b0;
    filter     = strm[2].f;
    conv_input = strm[2].d;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk_v("midreset valid", out_valid, 1'b0);
      chk("midreset data", conv_output, '0);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_v("post_reset idle", out_valid, 1'b0);
      chk("post_reset data", conv_output, '0);
    end
    apply_vec(strm[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/conv.md
Name: conv

Overview:
- Fixed-point 2-D convolution kernel: the dot product of a SIZE x SIZE filter window with a SIZE x SIZE input window, producing one N-bit result per accepted window.
- Sits in the convolution datapath; an upstream window generator feeds one window per cycle with a valid strobe.
- Fully pipelined: accepts a new window every clock; fixed latency of 3 cycles.

Parameters:
- SIZE, 7, window edge length; SIZE*SIZE elements per window (49 by default).
- N, 32, element and result width; signed two's complement fixed point.
- FRAC, 15, fractional bits per element. Default format is Q16.15: bit 31 sign, bits 30:15 integer, bits 14:0 fraction. 1.0 = 32'h0000_8000.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, qualifies filter/conv_input this cycle.
- filter, input, SIZE*SIZE*N, flattened filter window; element i = filter[i*N +: N], i = row*SIZE + col.
- conv_input, input, SIZE*SIZE*N, flattened data window; same packing as filter.
- out_valid, output, 1, conv_output holds a new result this cycle.
- conv_output, output, N, signed Q(N-1-FRAC).FRAC dot product, saturated.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, conv_output=0, all pipeline valid bits and data registers cleared. In-flight windows are discarded. First accept is on the first rising edge after rst_n deasserts.
- Stage 1, edge where in_valid=1: register both windows and set v1. When in_valid=0, v1 clears and the data registers may hold.
- Stage 2: compute 49 signed N x N products, each full precision (2N bits), and register them; v2 <= v1.
- Stage 3: sum all products at full precision with a 2N+ceil(log2(SIZE*SIZE)) bit accumulator (no intermediate overflow).
  - Arithmetic shift right by FRAC, which truncates toward minus infinity.
  - Saturate to signed N bits: max 2^(N-1)-1, min -2^(N-1).
  - Register the result into conv_output; out_valid <= v2.
- Latency: a window accepted on edge k appears with out_valid=1 after edge k+2, i.e. registered 3 edges inclusive. Throughput: 1 window per cycle; back-to-back in_valid yields back-to-back out_valid with no bubbles.
- When out_valid=0, conv_output holds its last value (0 after reset). Downstream logic must qualify it with out_valid.
- There is no backpressure. Results are produced unconditionally.
- Products of the most-negative value (-2^(N-1) x -2^(N-1)) fit in 2N bits without overflow. The final result saturates.
- Element ordering does not affect the result (commutative sum), but the packing above is mandatory for integration.

Test Plan:
- Reset check: hold rst_n=0 while driving in_valid=1 -> out_valid=0, conv_output=0 throughout. Release rst_n -> first out_valid exactly 3 edges after the first in_valid edge.
- Alternating ones: filter[i]=conv_input[i]=32'h0000_8000 (1.0) for odd i, 0 for even i, in_valid pulse -> out_valid one cycle, conv_output=24.0=32'h000C_0000.
- Fraction/truncation: all 49 elements of both windows =0.5 (32'h0000_4000) -> 12.25 = 32'h0006_2000. A single filter element of 1 LSB (2^-15) times data 0.5 -> 0 (truncated).
- Signed: filter all -1.0 (32'hFFFF_8000), data all 2.0 -> -98.0 = 32'hFFCF_0000. Mixed signs cancelling to zero -> 0.
- Saturation: all elements 32'h7FFF_FFFF -> conv_output=32'h7FFF_FFFF. Filter all max, data all 32'h8000_0000 -> 32'h8000_0000.
- Streaming/reset mid-op: 5 consecutive distinct windows -> 5 consecutive correct results in order. Repeat, asserting rst_n low after the 2nd accept -> no further out_valid until new input after reset.
